// File: rtl/mesi_isc_pkg.sv
// rtl/mesi_isc_pkg.sv - shared constants and types for the ISC line-lock front end
package mesi_isc_pkg;

    localparam int CPU_NUM  = 4;
    localparam int MBUS_NOP = 0;

    typedef enum logic [1:0] {
        LK_IDLE,
        LK_ISSUE,
        LK_WAIT_DONE
    } lock_state_t;

    function automatic logic [1:0] onehot4_to_idx(input logic [3:0] oh);
        logic [1:0] idx;
        case (oh)
            4'b0010: idx = 2'd1;
            4'b0100: idx = 2'd2;
            4'b1000: idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/mesi_isc_rr_arb4.sv
// rtl/mesi_isc_rr_arb4.sv - combinational 4-way round-robin pick starting at ptr
module mesi_isc_rr_arb4
    import mesi_isc_pkg::*;
(
    input  logic [3:0] eligible,
    input  logic [1:0] ptr,
    output logic [3:0] grant,
    output logic       valid
);

    logic [1:0] idx;

    // Scan from the far end back toward ptr so the closest eligible CPU wins last.
    always_comb begin
        grant = '0;
        valid = 1'b0;
        idx   = '0;
        for (int k = CPU_NUM - 1; k >= 0; k--) begin
            idx = ptr + 2'(k);
            if (eligible[idx]) begin
                grant = 4'b0001 << idx;
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mesi_isc_line_lock_arb.sv
// rtl/mesi_isc_line_lock_arb.sv - admits CPU requests to the ISC mbus, one per cycle,
// never letting two in-flight transactions share a cache line
module mesi_isc_line_lock_arb
    import mesi_isc_pkg::*;
#(
    parameter int MBUS_CMD_WIDTH = 3,
    parameter int ADDR_WIDTH     = 32,
    parameter int LINE_LSB       = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [4*MBUS_CMD_WIDTH-1:0] req_cmd_array_i,
    input  logic [4*ADDR_WIDTH-1:0]     req_addr_array_i,
    output logic [3:0]                  req_ack_array_o,
    input  logic [3:0]                  done_array_i,
    output logic [4*MBUS_CMD_WIDTH-1:0] mbus_cmd_array_o,
    output logic [4*ADDR_WIDTH-1:0]     mbus_addr_array_o,
    input  logic [3:0]                  mbus_ack_array_i,
    output logic [3:0]                  lock_busy_o,
    output logic                        proto_err_o
);

    localparam int LW = ADDR_WIDTH - LINE_LSB;
    localparam logic [MBUS_CMD_WIDTH-1:0] NOP = MBUS_CMD_WIDTH'(MBUS_NOP);

    lock_state_t               state     [CPU_NUM];
    logic [MBUS_CMD_WIDTH-1:0] mbus_cmd  [CPU_NUM];
    logic [ADDR_WIDTH-1:0]     mbus_addr [CPU_NUM];
    logic [MBUS_CMD_WIDTH-1:0] req_cmd   [CPU_NUM];
    logic [ADDR_WIDTH-1:0]     req_addr  [CPU_NUM];
    logic [LW-1:0]             req_line  [CPU_NUM];
    logic [LW-1:0]             lock_line [CPU_NUM];
    logic [3:0]                lock_valid;
    logic [3:0]                blocked;
    logic [3:0]                eligible;
    logic [3:0]                grant;
    logic                      grant_valid;
    logic [1:0]                rr_ptr;

    // The latched mbus address doubles as the lock table entry for that CPU.
    for (genvar g = 0; g < CPU_NUM; g++) begin : g_cpu
        assign req_cmd[g]   = req_cmd_array_i[g*MBUS_CMD_WIDTH +: MBUS_CMD_WIDTH];
        assign req_addr[g]  = req_addr_array_i[g*ADDR_WIDTH +: ADDR_WIDTH];
        assign req_line[g]  = req_addr[g][ADDR_WIDTH-1:LINE_LSB];
        assign lock_line[g] = mbus_addr[g][ADDR_WIDTH-1:LINE_LSB];
        assign lock_valid[g] = (state[g] != LK_IDLE);
        assign lock_busy_o[g] = lock_valid[g];
        assign mbus_cmd_array_o[g*MBUS_CMD_WIDTH +: MBUS_CMD_WIDTH] = mbus_cmd[g];
        assign mbus_addr_array_o[g*ADDR_WIDTH +: ADDR_WIDTH]        = mbus_addr[g];
    end

    always_comb begin
        blocked  = '0;
        eligible = '0;
        for (int i = 0; i < CPU_NUM; i++) begin
            for (int j = 0; j < CPU_NUM; j++) begin
                if (lock_valid[j] && (lock_line[j] == req_line[i])) begin
                    blocked[i] = 1'b1;
                end
            end
            eligible[i] = (state[i] == LK_IDLE) && (req_cmd[i] != NOP) && !blocked[i];
        end
    end

    mesi_isc_rr_arb4 u_rr_arb (
        .eligible (eligible),
        .ptr      (rr_ptr),
        .grant    (grant),
        .valid    (grant_valid)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < CPU_NUM; i++) begin
                state[i]     <= LK_IDLE;
                mbus_cmd[i]  <= NOP;
                mbus_addr[i] <= '0;
            end
            req_ack_array_o <= '0;
            proto_err_o     <= 1'b0;
            rr_ptr          <= '0;
        end else begin
            req_ack_array_o <= '0;
            for (int i = 0; i < CPU_NUM; i++) begin
                case (state[i])
                    LK_IDLE: begin
                        if (grant[i]) begin
                            state[i]     <= LK_ISSUE;
                            mbus_cmd[i]  <= req_cmd[i];
                            mbus_addr[i] <= req_addr[i];
                        end
                    end
                    LK_ISSUE: begin
                        if (mbus_ack_array_i[i]) begin
                            state[i]           <= LK_WAIT_DONE;
                            mbus_cmd[i]        <= NOP;
                            req_ack_array_o[i] <= 1'b1;
                        end
                    end
                    LK_WAIT_DONE: begin
                        if (done_array_i[i]) begin
                            state[i] <= LK_IDLE;
                        end
                    end
                    default: state[i] <= LK_IDLE;
                endcase
                if ((done_array_i[i] && (state[i] != LK_WAIT_DONE)) ||
                    (mbus_ack_array_i[i] && (state[i] != LK_ISSUE))) begin
                    proto_err_o <= 1'b1;
                end
            end
            if (grant_valid) begin
                rr_ptr <= onehot4_to_idx(grant) + 2'd1;
            end
        end
    end

endmodule

// File: tb/tb_mesi_isc_line_lock_arb.sv
// tb/tb_mesi_isc_line_lock_arb.sv - scoreboard bench for mesi_isc_line_lock_arb
module tb_mesi_isc_line_lock_arb;

    typedef struct {
        logic [11:0]  cmd;
        logic [127:0] addr;
        logic [3:0]   ack;
        logic [3:0]   busy;
        logic         err;
    } exp_t;

    logic         clk;
    logic         rst;
    logic [11:0]  req_cmd;
    logic [127:0] req_addr;
    logic [3:0]   req_ack;
    logic [3:0]   done;
    logic [11:0]  mbus_cmd;
    logic [127:0] mbus_addr;
    logic [3:0]   mbus_ack;
    logic [3:0]   lock_busy;
    logic         proto_err;

    int n_checks = 0;
    int n_fail   = 0;
    exp_t q[$];

    // Reference model: phase 0 = free, 1 = command on the bus, 2 = waiting for done.
    int          m_phase [4];
    logic [31:0] m_addr  [4];
    logic [2:0]  m_cmd   [4];
    int          m_ptr;
    logic        m_err;

    mesi_isc_line_lock_arb dut (
        .clk               (clk),
        .rst               (rst),
        .req_cmd_array_i   (req_cmd),
        .req_addr_array_i  (req_addr),
        .req_ack_array_o   (req_ack),
        .done_array_i      (done),
        .mbus_cmd_array_o  (mbus_cmd),
        .mbus_addr_array_o (mbus_addr),
        .mbus_ack_array_i  (mbus_ack),
        .lock_busy_o       (lock_busy),
        .proto_err_o       (proto_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_phase[i] = 0;
            m_addr[i]  = '0;
            m_cmd[i]   = '0;
        end
        m_ptr = 0;
        m_err = 1'b0;
    endtask

    task automatic model_step(input logic [11:0] c, input logic [127:0] a,
                              input logic [3:0] ack, input logic [3:0] dn, output exp_t e);
        bit elig [4];
        int winner = -1;
        for (int i = 0; i < 4; i++) begin
            elig[i] = (m_phase[i] == 0) && (c[i*3 +: 3] != 3'd0);
            for (int j = 0; j < 4; j++)
                if (m_phase[j] != 0 && m_addr[j][31:2] == a[i*32+2 +: 30]) elig[i] = 0;
        end
        for (int k = 0; k < 4; k++)
            if (winner < 0 && elig[(m_ptr + k) % 4]) winner = (m_ptr + k) % 4;
        e.ack = '0;
        for (int i = 0; i < 4; i++) begin
            if ((dn[i] && m_phase[i] != 2) || (ack[i] && m_phase[i] != 1)) m_err = 1'b1;
            if (m_phase[i] == 1 && ack[i]) begin
                m_phase[i] = 2;
                e.ack[i]   = 1'b1;
            end else if (m_phase[i] == 2 && dn[i]) begin
                m_phase[i] = 0;
            end
        end
        if (winner >= 0) begin
            m_phase[winner] = 1;
            m_cmd[winner]   = c[winner*3 +: 3];
            m_addr[winner]  = a[winner*32 +: 32];
            m_ptr           = (winner + 1) % 4;
        end
        for (int i = 0; i < 4; i++) begin
            e.cmd[i*3 +: 3]   = (m_phase[i] == 1) ? m_cmd[i] : 3'd0;
            e.addr[i*32 +: 32] = m_addr[i];
            e.busy[i]         = (m_phase[i] != 0);
        end
        e.err = m_err;
    endtask

    task automatic step(input logic [11:0] c, input logic [127:0] a,
                        input logic [3:0] ack, input logic [3:0] dn);
        exp_t e;
        @(negedge clk);
        req_cmd  = c;
        req_addr = a;
        mbus_ack = ack;
        done     = dn;
        model_step(c, a, ack, dn, e);
        q.push_back(e);
    endtask

    task automatic quiesce();
        logic [3:0] ack;
        logic [3:0] dn;
        for (int n = 0; n < 3; n++) begin
            for (int i = 0; i < 4; i++) begin
                ack[i] = (m_phase[i] == 1);
                dn[i]  = (m_phase[i] == 2);
            end
            step('0, '0, ack, dn);
        end
    endtask

    function automatic logic [11:0] cv(input int cpu, input logic [2:0] cmd);
        return 12'(cmd) << (cpu * 3);
    endfunction

    function automatic logic [127:0] av(input int cpu, input logic [31:0] addr);
        return 128'(addr) << (cpu * 32);
    endfunction

    task automatic after_edge();
        @(posedge clk);
        #3;
    endtask

    // Monitor: every cycle with an outstanding expectation is compared just after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("mbus_cmd",  128'(mbus_cmd),  128'(e.cmd));
                chk("mbus_addr", mbus_addr,       e.addr);
                chk("req_ack",   128'(req_ack),   128'(e.ack));
                chk("lock_busy", 128'(lock_busy), 128'(e.busy));
                chk("proto_err", 128'(proto_err), 128'(e.err));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        logic [11:0]  c;
        logic [127:0] a;
        logic [3:0]   ack;
        logic [3:0]   dn;
        rst      = 1'b0;
        req_cmd  = '0;
        req_addr = '0;
        mbus_ack = '0;
        done     = '0;
        model_reset();
        #3;
        chk("rst_cmd",  128'(mbus_cmd),  128'(0));
        chk("rst_addr", mbus_addr,       128'(0));
        chk("rst_ack",  128'(req_ack),   128'(0));
        chk("rst_busy", 128'(lock_busy), 128'(0));
        chk("rst_err",  128'(proto_err), 128'(0));
        #5 rst = 1'b1;

        for (int n = 0; n < 400; n++) begin
            c = '0; a = '0; ack = '0; dn = '0;
            for (int i = 0; i < 4; i++) begin
                if ($urandom_range(0, 9) < 6) c[i*3 +: 3] = 3'($urandom_range(1, 7));
                a[i*32 +: 32] = 32'h1000 + 32'($urandom_range(0, 5) * 4) + 32'($urandom_range(0, 3));
                if (m_phase[i] == 1 && $urandom_range(0, 1) == 1) ack[i] = 1'b1;
                if (m_phase[i] == 2 && $urandom_range(0, 9) < 3) dn[i] = 1'b1;
            end
            step(c, a, ack, dn);
        end
        quiesce();

        // Single request on CPU1.
        step(cv(1, 3'd1), av(1, 32'h100), '0, '0);
        after_edge();
        chk("tp1_cmd",  128'(mbus_cmd[5:3]),   128'(1));
        chk("tp1_addr", 128'(mbus_addr[63:32]), 128'(32'h100));
        step('0, '0, '0, '0);
        step('0, '0, 4'b0010, '0);
        after_edge();
        chk("tp1_ack",  128'(req_ack),   128'(4'b0010));
        chk("tp1_busy", 128'(lock_busy), 128'(4'b0010));
        step('0, '0, '0, '0);
        step('0, '0, '0, 4'b0010);
        step('0, '0, '0, '0);

        // Same-line block: CPU2 waits on CPU0's lock, then gets in one cycle after release.
        step(cv(0, 3'd2), av(0, 32'h200), '0, '0);
        step('0, '0, 4'b0001, '0);
        step(cv(2, 3'd1), av(2, 32'h201), '0, '0);
        step(cv(2, 3'd1), av(2, 32'h201), '0, '0);
        after_edge();
        chk("tp2_blocked", 128'(lock_busy), 128'(4'b0001));
        step(cv(2, 3'd1), av(2, 32'h201), '0, 4'b0001);
        after_edge();
        chk("tp2_release", 128'(lock_busy), 128'(4'b0000));
        step(cv(2, 3'd1), av(2, 32'h201), '0, '0);
        after_edge();
        chk("tp2_grant", 128'(mbus_cmd[8:6]), 128'(1));
        quiesce();

        // All four request distinct lines together.
        c = cv(0, 3'd1) | cv(1, 3'd2) | cv(2, 3'd3) | cv(3, 3'd4);
        a = av(0, 32'h300) | av(1, 32'h310) | av(2, 32'h320) | av(3, 32'h330);
        for (int n = 0; n < 4; n++) step(c, a, '0, '0);
        after_edge();
        chk("tp3_all_busy", 128'(lock_busy), 128'(4'b1111));
        quiesce();

        // Move pointer to 3, then CPU1 and CPU3 contend for line 0x40.
        step(cv(2, 3'd1), av(2, 32'h500), '0, '0);
        quiesce();
        c = cv(1, 3'd1) | cv(3, 3'd1);
        a = av(1, 32'h40) | av(3, 32'h40);
        step(c, a, '0, '0);
        after_edge();
        chk("tp4_winner", 128'(lock_busy), 128'(4'b1000));
        step(c, a, 4'b1000, '0);
        step(c, a, '0, 4'b1000);
        step(c, a, '0, '0);
        after_edge();
        chk("tp4_cpu1", 128'(lock_busy), 128'(4'b0010));
        quiesce();

        // Protocol errors.
        step('0, '0, '0, 4'b0100);
        after_edge();
        chk("tp5_err", 128'(proto_err), 128'(1));
        step(cv(0, 3'd1), av(0, 32'h600), '0, '0);
        step('0, '0, 4'b0001, 4'b0001);
        after_edge();
        chk("tp5_lock_kept", 128'(lock_busy), 128'(4'b0001));
        quiesce();

        // Asynchronous reset while CPU0 is on the bus.
        step(cv(0, 3'd1), av(0, 32'h700), '0, '0);
        @(posedge clk);
        #4;
        rst = 1'b0;
        model_reset();
        #1;
        chk("tp6_cmd",  128'(mbus_cmd),  128'(0));
        chk("tp6_busy", 128'(lock_busy), 128'(0));
        chk("tp6_err",  128'(proto_err), 128'(0));
        @(posedge clk);
        #3 rst = 1'b1;
        for (int n = 0; n < 3; n++) step('0, '0, '0, '0);

        repeat (2) @(posedge clk);
        #3;
        chk("drain", 128'(q.size()), 128'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
